regfile_reader: RTL and testbench

//   Register file with one write port and two read ports, the counterpart of the single-word

---
 rtl/regfile_reader.sv | 95 +++++++++
 tb/tb_regfile_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/regfile_reader.sv
// rtl/regfile_reader.sv - two-read/one-write register file with x0 = 0 and a pending-write scoreboard
// Reads are registered with a valid pulse; a same-cycle write to the read address is forwarded.
module regfile_reader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [WIDTH-1:0]  rd1,
  output logic              rv1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd2,
  output logic              rv2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_next;
  logic [WIDTH-1:0] rd1_next;
  logic [WIDTH-1:0] rd2_next;
  logic             wr_ok;
  logic             iss_ok;
  logic             ra1_ok;
  logic             ra2_ok;

  // Entry 0 and addresses beyond DEPTH are never storage; they read as zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < DEPTH);
  endfunction

  always_comb begin
    wr_ok  = we && addr_ok(wa);
    iss_ok = iss_en && addr_ok(iss_rd);
    ra1_ok = addr_ok(ra1);
    ra2_ok = addr_ok(ra2);
  end

  // Write-first forwarding so decode sees the value retiring this cycle.
  always_comb begin
    rd1_next = '0;
    rd2_next = '0;
    if (ra1_ok) begin
      if (wr_ok && (wa == ra1)) rd1_next = wd;
      else                      rd1_next = mem[ra1];
    end
    if (ra2_ok) begin
      if (wr_ok && (wa == ra2)) rd2_next = wd;
      else                      rd2_next = mem[ra2];
    end
  end

  // Clear on writeback first, then set on issue, so a new producer stays outstanding.
  always_comb begin
    pending_next = pending;
    if (wr_ok)  pending_next[wa] = 1'b0;
    if (iss_ok) pending_next[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd1     <= '0;
      rd2     <= '0;
      rv1     <= 1'b0;
      rv2     <= 1'b0;
      pending <= '0;
    end else begin
      if (wr_ok) mem[wa] <= wd;
      rv1 <= re1;
      rv2 <= re2;
      if (re1) rd1 <= rd1_next;
      if (re2) rd2 <= rd2_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    busy1 = ra1_ok ? pending[ra1] : 1'b0;
    busy2 = ra2_ok ? pending[ra2] : 1'b0;
  end

endmodule

// File: tb/tb_regfile_reader.sv
// tb/tb_regfile_reader.sv - table-driven, scoreboarded bench for regfile_reader
module tb_regfile_reader;

  logic        clk = 1'b0;
  logic        rst, we, re1, re2, iss_en;
  logic [4:0]  wa, ra1, ra2, iss_rd;
  logic [31:0] wd, rd1, rd2;
  logic        rv1, rv2, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_reader #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .re1(re1), .ra1(ra1), .rd1(rd1), .rv1(rv1),
    .re2(re2), .ra2(ra2), .rd2(rd2), .rv2(rv2),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy1(busy1), .busy2(busy2)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        chk_busy;
    logic        b1;
    logic        b2;
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
  } vec_t;

  typedef struct {
    int          tag;
    logic        v1;
    logic [31:0] d1;
    logic        v2;
    logic [31:0] d2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic rst_i, input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
    input logic re1_i, input logic [4:0] ra1_i, input logic re2_i, input logic [4:0] ra2_i,
    input logic iss_i, input logic [4:0] isr_i, input logic cb, input logic b1_i, input logic b2_i,
    input logic v1_i, input logic [31:0] d1_i, input logic v2_i, input logic [31:0] d2_i);
    vec_t v;
    v.rst = rst_i; v.we = we_i; v.wa = wa_i; v.wd = wd_i;
    v.re1 = re1_i; v.ra1 = ra1_i; v.re2 = re2_i; v.ra2 = ra2_i;
    v.iss_en = iss_i; v.iss_rd = isr_i; v.chk_busy = cb; v.b1 = b1_i; v.b2 = b2_i;
    v.v1 = v1_i; v.d1 = d1_i; v.v2 = v2_i; v.d2 = d2_i;
    return v;
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [31:0] k;
    k = 32'(i);
    return (k * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; we = v.we; wa = v.wa; wd = v.wd;
    re1 = v.re1; ra1 = v.ra1; re2 = v.re2; ra2 = v.ra2;
    iss_en = v.iss_en; iss_rd = v.iss_rd;
    #1;
    if (v.chk_busy) begin
      chk("busy1", tag, {31'b0, busy1}, {31'b0, v.b1});
      chk("busy2", tag, {31'b0, busy2}, {31'b0, v.b2});
    end
    e.tag = tag; e.v1 = v.v1; e.d1 = v.d1; e.v2 = v.v2; e.d2 = v.d2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", tag, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rv1", e.tag, {31'b0, rv1}, {31'b0, e.v1});
      chk("rd1", e.tag, rd1, e.d1);
      chk("rv2", e.tag, {31'b0, rv2}, {31'b0, e.v2});
      chk("rd2", e.tag, rd2, e.d2);
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; re1 = 1'b0; ra1 = '0;
    re2 = 1'b0; ra2 = '0; iss_en = 1'b0; iss_rd = '0;

    // rst flags we/wa/wd/re/ra/iss, chk_busy b1 b2, then expected v1 d1 v2 d2 after the edge
    tbl.push_back(mk(1,1,5'd4,32'h5555_5555,1,5'd4,1,5'd4,1,5'd4, 0,0,0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,5'd0,32'h0,0,5'd4,0,5'd0,0,5'd0, 1,0,0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd5,0,5'd4,0,5'd0, 1,0,0, 1,32'h0,0,32'h0));
    tbl.push_back(mk(0,1,5'd3,32'h0000_00A0,0,5'd0,0,5'd0,0,5'd0, 0,0,0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd3,0,5'd0,0,5'd0, 0,0,0, 1,32'h0000_00A0,0,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd0,0,5'd0,0,5'd0, 0,0,0, 0,32'h0000_00A0,0,32'h0));
    tbl.push_back(mk(0,1,5'd7,32'hDEAD_BEEF,0,5'd0,1,5'd7,0,5'd0, 0,0,0, 0,32'h0000_00A0,1,32'hDEAD_BEEF));
    tbl.push_back(mk(0,1,5'd0,32'hFFFF_FFFF,1,5'd0,1,5'd0,0,5'd0, 0,0,0, 1,32'h0,1,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd0,1,5'd0,0,5'd0, 0,0,0, 1,32'h0,1,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd7,1,5'd7,0,5'd0, 0,0,0, 1,32'hDEAD_BEEF,1,32'hDEAD_BEEF));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd9,0,5'd3,1,5'd9, 1,0,0, 0,32'hDEAD_BEEF,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd9,0,5'd3,0,5'd0, 1,1,0, 0,32'hDEAD_BEEF,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,1,5'd9,32'h1111_1111,0,5'd9,0,5'd9,1,5'd9, 1,1,1, 0,32'hDEAD_BEEF,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd9,0,5'd0,0,5'd0, 1,1,0, 0,32'hDEAD_BEEF,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,1,5'd9,32'h2222_2222,0,5'd9,0,5'd9,0,5'd0, 1,1,1, 0,32'hDEAD_BEEF,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd9,0,5'd9,0,5'd0, 1,0,0, 1,32'h2222_2222,0,32'hDEAD_BEEF));
    tbl.push_back(mk(0,1,5'd3,32'h1234_5678,1,5'd3,0,5'd9,0,5'd0, 1,0,0, 1,32'h1234_5678,0,32'hDEAD_BEEF));
    tbl.push_back(mk(1,0,5'd0,32'h0,1,5'd3,0,5'd0,1,5'd6, 0,0,0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,1,5'd3,1,5'd7,0,5'd0, 1,0,0, 1,32'h0,1,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd0,0,5'd6,1,5'd0, 1,0,0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,5'd0,32'h0,0,5'd0,0,5'd6,0,5'd0, 1,0,0, 0,32'h0,0,32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], i);
    end

    // Fill every architectural register, then read all back crosswise on both ports.
    for (int i = 1; i < 32; i++) begin
      run_cycle(mk(0,1,5'(i),pat(i),0,5'd0,0,5'd0,0,5'd0, 0,0,0, 0,32'h0,0,32'h0), 100 + i);
    end
    for (int i = 1; i < 32; i++) begin
      run_cycle(mk(0,0,5'd0,32'h0,1,5'(i),1,5'(32 - i),0,5'd0, 0,0,0, 1,pat(i),1,pat(32 - i)), 200 + i);
    end

    // Several registers pending at once; clearing one leaves the others busy.
    run_cycle(mk(0,0,5'd0,32'h0,0,5'd0,0,5'd0,1,5'd12, 0,0,0, 0,pat(31),0,pat(1)), 300);
    run_cycle(mk(0,0,5'd0,32'h0,0,5'd12,0,5'd13,1,5'd13, 1,1,0, 0,pat(31),0,pat(1)), 301);
    run_cycle(mk(0,1,5'd12,32'hCAFE_0012,0,5'd12,0,5'd13,0,5'd0, 1,1,1, 0,pat(31),0,pat(1)), 302);
    run_cycle(mk(0,0,5'd0,32'h0,1,5'd12,1,5'd13,0,5'd0, 1,0,1, 1,32'hCAFE_0012,1,pat(13)), 303);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
